tluh_atomic_ctrl: RTL and testbench

- Read-modify-write sequencer for TL-UH atomic requests (ArithmeticData, LogicalData). Also passes Get/PutFullData/PutPartialData through.
- Sits between the TL-UH device-side A/D channels and a single-port TL-UL-style memory port.
- Reads the old word, drives the functional-unit operand/operation ports, and writes the result back with the request mask.
- Returns AccessAckData carrying the old word. One transaction is in flight at a time.

---
 rtl/tluh_pkg.sv | 61 ++++++
 rtl/tluh_atomic_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_tluh_atomic_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tluh_pkg.sv
// Shared TL-UH opcodes, atomic operation codes, bus widths and the
// sequencer state type.
package tluh_pkg;

  localparam int unsigned TL_AW = 32;
  localparam int unsigned TL_DW = 32;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGICAL     = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  localparam logic [2:0] LOG_XOR  = 3'd0;
  localparam logic [2:0] LOG_OR   = 3'd1;
  localparam logic [2:0] LOG_AND  = 3'd2;
  localparam logic [2:0] LOG_SWAP = 3'd3;

  localparam logic [2:0] ARI_MIN  = 3'd0;
  localparam logic [2:0] ARI_MAX  = 3'd1;
  localparam logic [2:0] ARI_MINU = 3'd2;
  localparam logic [2:0] ARI_MAXU = 3'd3;
  localparam logic [2:0] ARI_ADD  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_EXEC,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_put(input logic [2:0] op);
    return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
  endfunction

  // Opcodes whose response carries data (AccessAckData).
  function automatic logic has_rsp_data(input logic [2:0] op);
    return (op == OP_ARITH) || (op == OP_LOGICAL) || (op == OP_GET);
  endfunction

  // Only word-sized transfers and defined atomic operations are accepted.
  function automatic logic req_legal(input logic [2:0] op, input logic [2:0] param,
                                     input logic [1:0] size);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET: ok = 1'b1;
      OP_ARITH:   ok = (param <= ARI_ADD);
      OP_LOGICAL: ok = (param <= LOG_SWAP);
      default:    ok = 1'b0;
    endcase
    return ok && (size == 2'd2);
  endfunction

endpackage

// File: rtl/tluh_atomic_ctrl.sv
// Read-modify-write sequencer: turns TL-UH atomics into a read, one
// functional-unit cycle and a masked write; Get/Put pass straight through.
module tluh_atomic_ctrl
  import tluh_pkg::*;
#(
  parameter int unsigned AW   = TL_AW,
  parameter int unsigned DW   = TL_DW,
  parameter int unsigned SRCW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_opcode_i,
  input  logic [2:0]        req_param_i,
  input  logic [1:0]        req_size_i,
  input  logic [SRCW-1:0]   req_source_i,
  input  logic [AW-1:0]     req_address_i,
  input  logic [DW/8-1:0]   req_mask_i,
  input  logic [DW-1:0]     req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [2:0]        rsp_opcode_o,
  output logic [SRCW-1:0]   rsp_source_o,
  output logic [DW-1:0]     rsp_data_o,
  output logic              rsp_error_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_be_o,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_err_i,
  output logic              fu_enable_o,
  output logic              fu_logical_o,
  output logic [2:0]        fu_operation_o,
  output logic [DW-1:0]     fu_op1_o,
  output logic [DW-1:0]     fu_op2_o,
  input  logic [DW-1:0]     fu_result_i
);

  localparam int unsigned BW = DW / 8;

  state_e          state_q, state_d;
  logic [2:0]      opcode_q, opcode_d, param_q, param_d;
  logic [SRCW-1:0] source_q, source_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [BW-1:0]   mask_q, mask_d;
  logic [DW-1:0]   data_q, data_d, old_q, old_d, wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [2:0]      rsp_opcode_q, rsp_opcode_d;
  logic [SRCW-1:0] rsp_source_q, rsp_source_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            fu_enable_q, fu_enable_d, fu_logical_q, fu_logical_d;
  logic [2:0]      fu_operation_q, fu_operation_d;
  logic [DW-1:0]   fu_op1_q, fu_op1_d, fu_op2_q, fu_op2_d;

  // Next-state/capture logic, then outputs decoded from the next state so
  // every port is a flop that lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    param_d  = param_q;
    source_d = source_q;
    addr_d   = addr_q;
    mask_d   = mask_q;
    data_d   = data_q;
    old_d    = old_q;
    wdata_d  = wdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          opcode_d = req_opcode_i;
          param_d  = req_param_i;
          source_d = req_source_i;
          addr_d   = req_address_i;
          mask_d   = req_mask_i;
          data_d   = req_data_i;
          wdata_d  = req_data_i;
          old_d    = '0;
          err_d    = 1'b0;
          if (!req_legal(req_opcode_i, req_param_i, req_size_i)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (is_put(req_opcode_i)) begin
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: if (mem_gnt_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (mem_err_i) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            old_d   = mem_rdata_i;
            state_d = (opcode_q == OP_GET) ? ST_RESP : ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        wdata_d = fu_result_i;
        state_d = ST_WR_REQ;
      end
      ST_WR_REQ: if (mem_gnt_i) state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (mem_rvalid_i) begin
          err_d   = mem_err_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d    = (state_d == ST_IDLE);
    rsp_valid_d    = 1'b0;
    rsp_opcode_d   = '0;
    rsp_source_d   = '0;
    rsp_data_d     = '0;
    rsp_error_d    = 1'b0;
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    mem_be_d       = '0;
    fu_enable_d    = 1'b0;
    fu_logical_d   = 1'b0;
    fu_operation_d = '0;
    fu_op1_d       = '0;
    fu_op2_d       = '0;

    case (state_d)
      ST_RD_REQ: begin
        mem_req_d  = 1'b1;
        mem_addr_d = addr_d;
        mem_be_d   = '1;
      end
      ST_EXEC: begin
        fu_enable_d    = 1'b1;
        fu_logical_d   = (opcode_d == OP_LOGICAL);
        fu_operation_d = param_d;
        fu_op1_d       = data_d;
        fu_op2_d       = old_d;
      end
      ST_WR_REQ: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d;
        mem_be_d    = mask_d;
      end
      ST_RESP: begin
        rsp_valid_d  = 1'b1;
        rsp_opcode_d = has_rsp_data(opcode_d) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        rsp_source_d = source_d;
        rsp_data_d   = err_d ? '0 : old_d;
        rsp_error_d  = err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      opcode_q       <= '0;
      param_q        <= '0;
      source_q       <= '0;
      addr_q         <= '0;
      mask_q         <= '0;
      data_q         <= '0;
      old_q          <= '0;
      wdata_q        <= '0;
      err_q          <= 1'b0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_opcode_q   <= '0;
      rsp_source_q   <= '0;
      rsp_data_q     <= '0;
      rsp_error_q    <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      fu_enable_q    <= 1'b0;
      fu_logical_q   <= 1'b0;
      fu_operation_q <= '0;
      fu_op1_q       <= '0;
      fu_op2_q       <= '0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      param_q        <= param_d;
      source_q       <= source_d;
      addr_q         <= addr_d;
      mask_q         <= mask_d;
      data_q         <= data_d;
      old_q          <= old_d;
      wdata_q        <= wdata_d;
      err_q          <= err_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_opcode_q   <= rsp_opcode_d;
      rsp_source_q   <= rsp_source_d;
      rsp_data_q     <= rsp_data_d;
      rsp_error_q    <= rsp_error_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      fu_enable_q    <= fu_enable_d;
      fu_logical_q   <= fu_logical_d;
      fu_operation_q <= fu_operation_d;
      fu_op1_q       <= fu_op1_d;
      fu_op2_q       <= fu_op2_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_opcode_o   = rsp_opcode_q;
  assign rsp_source_o   = rsp_source_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_error_o    = rsp_error_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_be_o       = mem_be_q;
  assign fu_enable_o    = fu_enable_q;
  assign fu_logical_o   = fu_logical_q;
  assign fu_operation_o = fu_operation_q;
  assign fu_op1_o       = fu_op1_q;
  assign fu_op2_o       = fu_op2_q;

endmodule

// File: tb/tb_tluh_atomic_ctrl.sv
// Directed bench for tluh_atomic_ctrl: bench-side memory and functional
// units, a transaction-level model and a per-cycle output checker.
module tb_tluh_atomic_ctrl;
  import tluh_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SRCW = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            req_valid_i, req_ready_o;
  logic [2:0]      req_opcode_i, req_param_i;
  logic [1:0]      req_size_i;
  logic [SRCW-1:0] req_source_i;
  logic [AW-1:0]   req_address_i;
  logic [3:0]      req_mask_i;
  logic [DW-1:0]   req_data_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [2:0]      rsp_opcode_o;
  logic [SRCW-1:0] rsp_source_o;
  logic [DW-1:0]   rsp_data_o;
  logic            mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o, mem_rdata_i;
  logic [3:0]      mem_be_o;
  logic            fu_enable_o, fu_logical_o;
  logic [2:0]      fu_operation_o;
  logic [DW-1:0]   fu_op1_o, fu_op2_o, fu_result_i;

  tluh_atomic_ctrl #(.AW(AW), .DW(DW), .SRCW(SRCW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i), .req_param_i(req_param_i), .req_size_i(req_size_i),
    .req_source_i(req_source_i), .req_address_i(req_address_i),
    .req_mask_i(req_mask_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_opcode_o(rsp_opcode_o),
    .rsp_source_o(rsp_source_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .fu_enable_o(fu_enable_o), .fu_logical_o(fu_logical_o),
    .fu_operation_o(fu_operation_o), .fu_op1_o(fu_op1_o), .fu_op2_o(fu_op2_o),
    .fu_result_i(fu_result_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Functional units as the parent would provide them.
  function automatic logic [31:0] fu_calc(input logic logical, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    if (logical) begin
      case (op)
        3'd0: return a ^ b;
        3'd1: return a | b;
        3'd2: return a & b;
        3'd3: return a;
        default: return 32'd0;
      endcase
    end
    case (op)
      3'd0: return ($signed(a) < $signed(b)) ? a : b;
      3'd1: return ($signed(a) > $signed(b)) ? a : b;
      3'd2: return (a < b) ? a : b;
      3'd3: return (a > b) ? a : b;
      3'd4: return a + b;
      default: return 32'd0;
    endcase
  endfunction

  assign fu_result_i = fu_calc(fu_logical_o, fu_operation_o, fu_op1_o, fu_op2_o);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level expectations for the request in flight.
  logic        busy = 1'b0, chk_en = 1'b0;
  logic        exp_rd, exp_wr, exp_fu, exp_logical, exp_err;
  logic [2:0]  exp_param, exp_rsp_op;
  logic [7:0]  exp_src;
  logic [31:0] exp_addr, exp_data, exp_old, exp_wdata, exp_rsp_data;
  logic [3:0]  exp_mask;
  int          fu_cyc_cnt, rd_seen, wr_seen;
  logic [31:0] last_rsp_data;
  logic        last_err;
  logic [2:0]  last_op;

  // Bench memory: grant after gnt_delay waiting cycles, respond one cycle later.
  logic [31:0] mem [256];
  int          gnt_delay = 0;
  bit          rd_err_inj = 1'b0;

  initial begin
    int wait_cnt;
    logic hs, hs_we, edge_rst;
    logic [31:0] hs_addr, hs_wdata;
    logic [3:0]  hs_be;
    wait_cnt = 0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    forever begin
      @(negedge clk_i);
      hs = mem_gnt_i && mem_req_o;
      hs_we = mem_we_o; hs_addr = mem_addr_o; hs_wdata = mem_wdata_o; hs_be = mem_be_o;
      @(posedge clk_i);
      edge_rst = rst_ni;
      #2;
      mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
      if (hs && edge_rst) begin
        mem_rvalid_i = 1'b1;
        if (hs_we) mem[hs_addr[7:0]] = merge(mem[hs_addr[7:0]], hs_wdata, hs_be);
        else if (rd_err_inj) mem_err_i = 1'b1;
        else mem_rdata_i = mem[hs_addr[7:0]];
      end
      if (rst_ni && mem_req_o) begin
        if (wait_cnt >= gnt_delay) begin mem_gnt_i = 1'b1; wait_cnt = 0; end
        else begin mem_gnt_i = 1'b0; wait_cnt++; end
      end else begin
        mem_gnt_i = 1'b0; wait_cnt = 0;
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni && chk_en) begin
        check("req_ready", 32'(req_ready_o), 32'(!busy));
        if (fu_enable_o) begin
          fu_cyc_cnt++;
          check("fu_allowed", 32'(exp_fu), 32'd1);
          check("fu_logical", 32'(fu_logical_o), 32'(exp_logical));
          check("fu_operation", 32'(fu_operation_o), 32'(exp_param));
          check("fu_op1", fu_op1_o, exp_data);
          check("fu_op2", fu_op2_o, exp_old);
        end else begin
          check("fu_idle", (fu_op1_o | fu_op2_o) | {28'd0, fu_logical_o, fu_operation_o}, 32'd0);
        end
        if (mem_req_o && !mem_we_o) begin
          rd_seen++;
          check("rd_allowed", 32'(exp_rd), 32'd1);
          check("rd_addr", mem_addr_o, exp_addr);
          check("rd_be", 32'(mem_be_o), 32'hF);
        end
        if (mem_req_o && mem_we_o) begin
          wr_seen++;
          check("wr_allowed", 32'(exp_wr), 32'd1);
          check("wr_addr", mem_addr_o, exp_addr);
          check("wr_be", 32'(mem_be_o), 32'(exp_mask));
          check("wr_data", mem_wdata_o, exp_wdata);
        end
        if (rsp_valid_o) begin
          check("rsp_in_txn", 32'(busy), 32'd1);
          check("rsp_opcode", 32'(rsp_opcode_o), 32'(exp_rsp_op));
          check("rsp_source", 32'(rsp_source_o), 32'(exp_src));
          check("rsp_data", rsp_data_o, exp_rsp_data);
          check("rsp_error", 32'(rsp_error_o), 32'(exp_err));
        end
      end
    end
  end

  task automatic set_model(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                           input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] data, input bit rderr);
    logic legal, atomic;
    atomic = (op == 3'd2) || (op == 3'd3);
    legal  = (size == 2'd2) && ((op <= 3'd1) || (op == 3'd4) ||
             (op == 3'd3 && param <= 3'd3) || (op == 3'd2 && param <= 3'd4));
    exp_rd      = legal && (atomic || op == 3'd4);
    exp_fu      = legal && atomic && !rderr;
    exp_wr      = legal && ((op <= 3'd1) || (atomic && !rderr));
    exp_logical = (op == 3'd3);
    exp_param   = param;
    exp_src     = src;
    exp_addr    = addr;
    exp_mask    = mask;
    exp_data    = data;
    exp_old     = mem[addr[7:0]];
    exp_wdata   = (op <= 3'd1) ? data : fu_calc(op == 3'd3, param, data, exp_old);
    exp_err     = !legal || (exp_rd && rderr);
    exp_rsp_op  = (atomic || op == 3'd4) ? 3'd1 : 3'd0;
    exp_rsp_data = (exp_err || op <= 3'd1) ? 32'd0 : exp_old;
  endtask

  // Returns the cycle of acceptance; req_valid is held until the handshake.
  task automatic send_req(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                          input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, output int c0);
    bit ok;
    ok = 1'b0;
    @(posedge clk_i); #2;
    req_valid_i = 1'b1; req_opcode_i = op; req_param_i = param; req_size_i = size;
    req_source_i = src; req_address_i = addr; req_mask_i = mask; req_data_i = data;
    c0 = cyc;
    for (int k = 0; k < 200; k++) begin
      if (req_ready_o) begin ok = 1'b1; c0 = cyc; break; end
      @(posedge clk_i); #2;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk_i); #2;
    req_valid_i = 1'b0; req_data_i = ~data; req_address_i = ~addr; req_opcode_i = 3'd7;
    busy = 1'b1;
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                         input logic [7:0] src, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input int gdelay, input int rstall,
                         input bit rderr, input int exp_lat);
    int c0, seen, stall;
    bit done;
    logic [31:0] exp_new;
    set_model(op, param, size, src, addr, mask, data, rderr);
    exp_new = exp_wr ? merge(exp_old, exp_wdata, mask) : exp_old;
    fu_cyc_cnt = 0; rd_seen = 0; wr_seen = 0;
    gnt_delay = gdelay; rd_err_inj = rderr;
    send_req(op, param, size, src, addr, mask, data, c0);
    seen = -1; done = 1'b0; stall = rstall;
    for (int k = 0; k < 300; k++) begin
      if (rsp_valid_o) begin
        if (seen < 0) seen = cyc;
        if (stall > 0) begin
          rsp_ready_i = 1'b0; stall--;
        end else begin
          rsp_ready_i = 1'b1;
          last_rsp_data = rsp_data_o; last_err = rsp_error_o; last_op = rsp_opcode_o;
          @(posedge clk_i); #2;
          rsp_ready_i = 1'b0; busy = 1'b0; done = 1'b1;
          break;
        end
      end
      @(posedge clk_i); #2;
    end
    if (!done) begin
      check("rsp_timeout", 32'd0, 32'd1);
      busy = 1'b0;
    end
    check("fu_cycles", 32'(fu_cyc_cnt), exp_fu ? 32'd1 : 32'd0);
    check("rd_issued", 32'(rd_seen > 0), 32'(exp_rd));
    check("wr_issued", 32'(wr_seen > 0), 32'(exp_wr));
    check("mem_after", mem[addr[7:0]], exp_new);
    if (exp_lat > 0) check("latency", 32'(seen - c0), 32'(exp_lat));
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    check({tag, "_ctl"}, 32'({rsp_valid_o, rsp_error_o, mem_req_o, mem_we_o, fu_enable_o,
                              fu_logical_o, fu_operation_o, rsp_opcode_o, mem_be_o}), 32'd0);
    check({tag, "_rsp"}, rsp_data_o | 32'(rsp_source_o), 32'd0);
    check({tag, "_mem"}, mem_addr_o | mem_wdata_o, 32'd0);
    check({tag, "_fu"}, fu_op1_o | fu_op2_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit ok;
    rst_ni = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    req_opcode_i = '0; req_param_i = '0; req_size_i = '0; req_source_i = '0;
    req_address_i = '0; req_mask_i = '0; req_data_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h10] = 32'hF0F0_F0F0;
    mem[8'h14] = 32'hAAAA_AAAA;
    mem[8'h18] = 32'h0000_0001;
    mem[8'h20] = 32'hDEAD_BEEF;
    mem[8'h24] = 32'h1357_9BDF;
    mem[8'h30] = 32'h1111_1111;
    mem[8'h40] = 32'h0000_0005;
    mem[8'h44] = 32'hFFFF_FFF0;
    mem[8'h48] = 32'hFFFF_FFF0;
    repeat (3) @(posedge clk_i);
    #2;
    check_all_idle("reset");
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // LogicalData XOR
    run_txn(3'd3, 3'd0, 2'd2, 8'h11, 32'h10, 4'hF, 32'h0FF0_0FF0, 0, 0, 1'b0, 6);
    check("xor_rsp_data", last_rsp_data, 32'hF0F0_F0F0);
    check("xor_mem", mem[8'h10], 32'hFF00_FF00);
    check("xor_rsp_op", 32'(last_op), 32'd1);
    // LogicalData SWAP, partial mask
    run_txn(3'd3, 3'd3, 2'd2, 8'h22, 32'h14, 4'h3, 32'h1234_5678, 0, 0, 1'b0, 6);
    check("swap_rsp_data", last_rsp_data, 32'hAAAA_AAAA);
    check("swap_mem", mem[8'h14], 32'hAAAA_5678);
    // Illegal logical param
    run_txn(3'd3, 3'd5, 2'd2, 8'h33, 32'h18, 4'hF, 32'hFFFF_FFFF, 0, 0, 1'b0, 0);
    check("badparam_err", 32'(last_err), 32'd1);
    check("badparam_data", last_rsp_data, 32'd0);
    // Get with grant delay and response back-pressure
    run_txn(3'd4, 3'd0, 2'd2, 8'h44, 32'h20, 4'hF, 32'h0, 3, 2, 1'b0, 0);
    check("get_data", last_rsp_data, 32'hDEAD_BEEF);
    // Zero-wait Get latency
    run_txn(3'd4, 3'd0, 2'd2, 8'h45, 32'h24, 4'hF, 32'h0, 0, 0, 1'b0, 3);
    // Atomic AND with read error
    run_txn(3'd3, 3'd2, 2'd2, 8'h55, 32'h18, 4'hF, 32'h0, 0, 0, 1'b1, 0);
    check("rderr_err", 32'(last_err), 32'd1);
    check("rderr_op", 32'(last_op), 32'd1);
    check("rderr_data", last_rsp_data, 32'd0);
    check("rderr_mem", mem[8'h18], 32'h0000_0001);
    // Arithmetic ADD, MIN (signed), MINU
    run_txn(3'd2, 3'd4, 2'd2, 8'h66, 32'h40, 4'hF, 32'hFFFF_FFFE, 0, 0, 1'b0, 6);
    check("add_mem", mem[8'h40], 32'h0000_0003);
    check("add_rsp", last_rsp_data, 32'h0000_0005);
    run_txn(3'd2, 3'd0, 2'd2, 8'h67, 32'h44, 4'hF, 32'h0000_0005, 1, 1, 1'b0, 0);
    check("min_mem", mem[8'h44], 32'hFFFF_FFF0);
    run_txn(3'd2, 3'd2, 2'd2, 8'h68, 32'h48, 4'hF, 32'h0000_0005, 0, 0, 1'b0, 6);
    check("minu_mem", mem[8'h48], 32'h0000_0005);
    // Puts
    run_txn(3'd0, 3'd0, 2'd2, 8'h77, 32'h50, 4'hF, 32'hCAFE_F00D, 0, 0, 1'b0, 3);
    check("putfull_mem", mem[8'h50], 32'hCAFE_F00D);
    check("putfull_op", 32'(last_op), 32'd0);
    run_txn(3'd1, 3'd0, 2'd2, 8'h78, 32'h54, 4'hC, 32'h1234_5678, 2, 0, 1'b0, 0);
    check("putpart_mem", mem[8'h54], 32'h1234_0000);
    check("putpart_data", last_rsp_data, 32'd0);
    // Illegal size, unknown opcode, arithmetic param out of range
    run_txn(3'd4, 3'd0, 2'd1, 8'h88, 32'h20, 4'hF, 32'h0, 0, 0, 1'b0, 0);
    run_txn(3'd6, 3'd0, 2'd2, 8'h89, 32'h20, 4'hF, 32'h0, 0, 0, 1'b0, 0);
    check("unknown_op", 32'(last_op), 32'd0);
    run_txn(3'd2, 3'd5, 2'd2, 8'h8A, 32'h20, 4'hF, 32'h0, 0, 0, 1'b0, 0);

    // Reset while a Put waits for its write grant
    set_model(3'd0, 3'd0, 2'd2, 8'h99, 32'h30, 4'hF, 32'h5555_5555, 1'b0);
    gnt_delay = 1000; rd_err_inj = 1'b0;
    send_req(3'd0, 3'd0, 2'd2, 8'h99, 32'h30, 4'hF, 32'h5555_5555, c0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (mem_req_o && mem_we_o) begin ok = 1'b1; break; end
      @(posedge clk_i); #2;
    end
    check("reach_wr_req", 32'(ok), 32'd1);
    @(posedge clk_i); #2;
    chk_en = 1'b0; rst_ni = 1'b0;
    @(posedge clk_i); #2;
    check_all_idle("midrst");
    rst_ni = 1'b1; busy = 1'b0; exp_wr = 1'b0; exp_rd = 1'b0; exp_fu = 1'b0;
    chk_en = 1'b1; gnt_delay = 0;
    repeat (5) @(posedge clk_i);
    #2;
    check("midrst_mem", mem[8'h30], 32'h1111_1111);
    run_txn(3'd4, 3'd0, 2'd2, 8'hAB, 32'h30, 4'hF, 32'h0, 0, 0, 1'b0, 3);
    check("post_rst_get", last_rsp_data, 32'h1111_1111);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
